dmem_arbiter: RTL

Sequences and shares the synchronous data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA port). Each port issues word/half/byte loads and stores over a valid/ready request channel and receives a formatted response (sign/zero-extended load data, error flag). The block generates the memory's registered RD/WR/addr/data/byte-enable strobes, one access at a time, with round-robin arbitration. It sits between the pipeline MEM stage, the debug port and the data memory.

---
 rtl/dmem_arb_pkg.sv | 30 +++
 rtl/dmem_lane_fmt.sv | 60 ++++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: access size
// encoding, arbiter FSM states and byte-enable patterns.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // One-hot response-valid pattern for a port number.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Size/offset decoding for one memory access: legality, byte enables,
// low-aligned store data, and load lane extraction with sign/zero extension.
module dmem_lane_fmt
    import dmem_arb_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata_fmt,
    output logic [31:0] rdata_fmt
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    logic        in_range;
    logic [31:0] lane;

    assign in_range = ({1'b0, addr} < ADDR_LIMIT);
    // Bring the addressed byte/half down to bit 0 of the fetched word.
    assign lane     = rword >> {addr[1:0], 3'b000};

    // Decode size and offset into legality, strobes and formatted data.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        legal     = 1'b1;
        be        = BE_NONE;
        wdata_fmt = '0;
        rdata_fmt = '0;
        case (size_e'(size))
            SZ_BYTE: begin
                be        = BE_BYTE0 << addr[1:0];
                wdata_fmt = {24'd0, wdata[7:0]};
                rdata_fmt = is_unsigned ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                legal     = ~addr[0];
                be        = addr[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_fmt = {16'd0, wdata[15:0]};
                rdata_fmt = is_unsigned ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            end
            SZ_WORD: begin
                legal     = (addr[1:0] == 2'b00);
                be        = BE_WORD;
                wdata_fmt = wdata;
                rdata_fmt = rword;
            end
            default: legal = 1'b0;
        endcase
        if (!in_range) begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant, one access in flight,
// registered memory strobes and a held, formatted response per port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_we,
    input  logic [1:0][1:0]  req_size,
    input  logic [1:0]       req_unsigned,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [31:0]      mem_rdata
);

    state_e      state;
    logic        last_grant;
    logic        owner;
    logic [1:0]  own_size;
    logic [1:0]  own_off;
    logic        own_uns;

    logic        grant;
    logic        accept;

    logic [1:0]  fmt_size;
    logic [31:0] fmt_addr;
    logic        fmt_uns;
    logic        fmt_legal;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_rdata;

    // Round-robin choice in IDLE: on contention the port not granted last wins.
    always_comb begin
        grant     = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
        if (state == IDLE && req_valid != 2'b00) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    // The formatter decodes the incoming request in IDLE and the captured
    // owner request in WAIT, so one instance serves both directions.
    assign fmt_size = (state == WAIT) ? own_size : req_size[grant];
    assign fmt_addr = (state == WAIT) ? {30'd0, own_off} : req_addr[grant];
    assign fmt_uns  = (state == WAIT) ? own_uns : req_unsigned[grant];

    dmem_lane_fmt #(
        .MEM_WORDS (MEM_WORDS)
    ) u_fmt (
        .size        (fmt_size),
        .addr        (fmt_addr),
        .is_unsigned (fmt_uns),
        .wdata       (req_wdata[grant]),
        .rword       (mem_rdata),
        .legal       (fmt_legal),
        .be          (fmt_be),
        .wdata_fmt   (fmt_wdata),
        .rdata_fmt   (fmt_rdata)
    );

    // Transaction sequencer with registered memory strobes and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            own_size   <= '0;
            own_off    <= '0;
            own_uns    <= 1'b0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant;
                        last_grant <= grant;
                        own_size   <= req_size[grant];
                        own_off    <= req_addr[grant][1:0];
                        own_uns    <= req_unsigned[grant];
                        if (fmt_legal) begin
                            mem_addr  <= req_addr[grant];
                            mem_wdata <= fmt_wdata;
                            mem_be    <= fmt_be;
                            mem_rd    <= ~req_we[grant];
                            mem_wr    <= req_we[grant];
                            state     <= CMD;
                        end else begin
                            rsp_valid <= port_onehot(grant);
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end
                    end
                end
                CMD: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    if (mem_wr) begin
                        rsp_valid <= port_onehot(owner);
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rsp_rdata <= fmt_rdata;
                    rsp_err   <= 1'b0;
                    rsp_valid <= port_onehot(owner);
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
